// File: rtl/uart_pkg.sv
// Shared encodings and small helpers for the configurable UART receive engine.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Unsupported widths fall back to the classic 8-bit frame.
    function automatic logic [3:0] eff_dbits(input logic [3:0] d);
        if ((d >= 4'd5) && (d <= 4'd9)) begin
            return d;
        end else begin
            return 4'd8;
        end
    endfunction

endpackage

// File: rtl/uart_sync_vote.sv
// Line synchroniser plus the two-sample history that feeds the 3-way bit vote.
module uart_sync_vote
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick_i,
    input  logic rx_i,
    output logic rxs_o,
    output logic voted_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q;

    // Metastability chain; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    // The two previous tick samples; the vote at tick n uses n-2, n-1 and n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (baud_tick_i) begin
            hist_q <= {hist_q[0], rxs_o};
        end else begin
            hist_q <= hist_q;
        end
    end

    assign rxs_o   = sync_q[SYNC_STAGES-1];
    assign voted_o = maj3(hist_q[1], hist_q[0], rxs_o);

endmodule

// File: rtl/uart_rx_fe.sv
// UART receive engine: 5-9 data bits, optional parity, 1/2 stop bits,
// break detection and a one-deep valid/ready holding register.
module uart_rx_fe
    import uart_pkg::*;
#(
    parameter int DBIT_MAX    = 9,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_tick,
    input  logic                rx_in,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic [DBIT_MAX-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                overrun,
    output logic                busy
);

    localparam logic [3:0] TICK_MID  = 4'(OVS / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

    logic rxs_s, voted_s, bit_end_s, par_en_s, eof_s, brk_s, ferr_fin_s, hs_s;

    logic [2:0]          state_q, state_d;
    logic [3:0]          tick_q, tick_d, bit_q, bit_d, dbits_q, dbits_d;
    logic [1:0]          par_q, par_d;
    logic                stop2_q, stop2_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                zero_q, zero_d, brkf_q, brkf_d, brk_wait_q, brk_wait_d;
    logic [DBIT_MAX-1:0] shift_q, shift_d, dout_q;
    logic                dout_valid_q, perr_out_q, ferr_out_q, break_q, overrun_q, busy_q;

    uart_sync_vote #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .baud_tick_i (baud_tick),
        .rx_i        (rx_in),
        .rxs_o       (rxs_s),
        .voted_o     (voted_s)
    );

    assign bit_end_s  = (tick_q == TICK_LAST);
    assign par_en_s   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign ferr_fin_s = ferr_q | ~voted_s;
    assign hs_s       = dout_valid_q & dout_ready;

    // Frame sequencing; everything moves only on baud_tick.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        dbits_d    = dbits_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        brkf_d     = brkf_q;
        brk_wait_d = brk_wait_q;
        eof_s      = 1'b0;
        brk_s      = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (brk_wait_q) begin
                        brk_wait_d = ~rxs_s;
                    end else if (!rxs_s) begin
                        state_d = START;
                        tick_d  = 4'd0;
                        bit_d   = 4'd0;
                        dbits_d = eff_dbits(cfg_dbits);
                        par_d   = cfg_parity;
                        stop2_d = cfg_stop2;
                        shift_d = {DBIT_MAX{1'b0}};
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        zero_d  = 1'b1;
                        brkf_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = 4'd0;
                        bit_d   = 4'd0;
                        state_d = rxs_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        tick_d  = 4'd0;
                        shift_d = shift_q | (DBIT_MAX'(voted_s) << bit_q);
                        zero_d  = zero_q & ~voted_s;
                        if (bit_q == (dbits_q - 4'd1)) begin
                            bit_d   = 4'd0;
                            state_d = par_en_s ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        tick_d  = 4'd0;
                        perr_d  = (^shift_q) ^ voted_s ^ (par_q == PAR_ODD);
                        zero_d  = zero_q & ~voted_s;
                        bit_d   = 4'd0;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        tick_d = 4'd0;
                        ferr_d = ferr_fin_s;
                        if ((bit_q == 4'd0) && stop2_q) begin
                            brkf_d = zero_q & ~voted_s;
                            bit_d  = 4'd1;
                        end else begin
                            // A break is judged on the first stop bit only.
                            brk_s      = (bit_q == 4'd0) ? (zero_q & ~voted_s) : brkf_q;
                            eof_s      = 1'b1;
                            brk_wait_d = brk_s;
                            bit_d      = 4'd0;
                            state_d    = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = 4'd0;
                    bit_d   = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Receiver state, latched frame configuration and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 4'd0;
            dbits_q    <= 4'd8;
            par_q      <= PAR_NONE;
            stop2_q    <= 1'b0;
            shift_q    <= {DBIT_MAX{1'b0}};
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            brkf_q     <= 1'b0;
            brk_wait_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            dbits_q    <= dbits_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            brkf_q     <= brkf_d;
            brk_wait_q <= brk_wait_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Holding register: a completed frame may replace a word being handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= {DBIT_MAX{1'b0}};
            dout_valid_q <= 1'b0;
            perr_out_q   <= 1'b0;
            ferr_out_q   <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            break_q <= brk_s;
            if (eof_s && (!dout_valid_q || hs_s)) begin
                dout_q       <= shift_q;
                dout_valid_q <= 1'b1;
                perr_out_q   <= perr_q;
                ferr_out_q   <= ferr_fin_s;
                overrun_q    <= hs_s ? 1'b0 : overrun_q;
            end else if (eof_s) begin
                overrun_q <= 1'b1;
            end else if (hs_s) begin
                dout_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end else begin
                dout_valid_q <= dout_valid_q;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign break_det  = break_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fe.sv
// Directed plus randomized bench for uart_rx_fe with a frame-level reference model.
module tb_uart_rx_fe;

    localparam int OVS = 16;

    logic       clk = 1'b0;
    logic       rst, baud_tick, rx_in, cfg_stop2, dout_ready;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic [8:0] dout;
    logic       dout_valid, parity_err, frame_err, break_det, overrun, busy;

    int total = 0;
    int bad   = 0;
    int brk_cnt = 0;
    int exp_brk = 0;

    logic       exp_valid, exp_pe, exp_fe, exp_ovr;
    logic [8:0] exp_word;

    uart_rx_fe #(.DBIT_MAX(9), .OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .baud_tick  (baud_tick),
        .rx_in      (rx_in),
        .cfg_dbits  (cfg_dbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .break_det  (break_det),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (break_det === 1'b1) brk_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic v);
        rx_in = v;
        @(negedge clk) baud_tick = 1'b1;
        @(negedge clk) baud_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1);
    endtask

    task automatic play_bit(input logic v, input int glitch_off);
        for (int t = 0; t < OVS; t++) tick((t == glitch_off) ? ~v : v);
    endtask

    // Plays one frame on the line, then updates the expected holding-register state.
    task automatic send_frame(input logic [8:0] data, input logic [3:0] dcfg, input logic [1:0] par,
                              input logic pbit, input logic s1, input logic s2, input logic stop2,
                              input int glitch_bit, input bit scramble);
        int         nb;
        logic       par_on, pe, fe, brk;
        logic [8:0] w;
        nb     = ((dcfg >= 4'd5) && (dcfg <= 4'd9)) ? int'(dcfg) : 8;
        par_on = (par == 2'b01) || (par == 2'b10);
        cfg_dbits = dcfg; cfg_parity = par; cfg_stop2 = stop2;
        play_bit(1'b0, -1);
        if (scramble) begin
            cfg_dbits = 4'($urandom); cfg_parity = 2'($urandom); cfg_stop2 = 1'($urandom);
        end
        for (int i = 0; i < nb; i++) play_bit(data[i], (i == glitch_bit) ? 8 : -1);
        if (par_on) play_bit(pbit, -1);
        play_bit(s1, -1);
        if (stop2) play_bit(s2, -1);
        idle(16);
        w   = data & ((9'd1 << nb) - 9'd1);
        pe  = 1'b0;
        if (par == 2'b01) pe = (($countones(w) + int'(pbit)) % 2) == 1;
        if (par == 2'b10) pe = (($countones(w) + int'(pbit)) % 2) == 0;
        fe  = !s1 || (stop2 && !s2);
        brk = (w == 9'd0) && (!par_on || !pbit) && !s1;
        if (brk) exp_brk++;
        if (!exp_valid) begin
            exp_valid = 1'b1; exp_word = w; exp_pe = pe; exp_fe = fe;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_valid"}, 32'(dout_valid), 32'(exp_valid));
        chk({tag, "_dout"}, 32'(dout), 32'(exp_word));
        chk({tag, "_perr"}, 32'(parity_err), 32'(exp_pe));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, "_brk"}, 32'(brk_cnt), 32'(exp_brk));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk) dout_ready = 1'b1;
        @(negedge clk) dout_ready = 1'b0;
        exp_valid = 1'b0; exp_ovr = 1'b0;
        chk({tag, "_hs_valid"}, 32'(dout_valid), 32'(exp_valid));
        chk({tag, "_hs_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        logic [8:0] rd;
        logic [3:0] rdb;
        logic [1:0] rpar;
        logic       rp, rs1, rst2;

        rst = 1'b1; baud_tick = 1'b0; rx_in = 1'b1; dout_ready = 1'b0;
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        exp_valid = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0; exp_word = 9'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_brk", 32'(break_det), 32'd0);
        chk("rst_flags", 32'({parity_err, frame_err}), 32'd0);
        rst = 1'b0;
        idle(4);

        // 8N1 0xA5
        send_frame(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        check_hold("8n1");
        chk("8n1_word", 32'(dout), 32'h0A5);
        handshake("8n1");

        // 7E1 with wrong then correct parity
        send_frame(9'h041, 4'd7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        check_hold("7e1_bad");
        chk("7e1_bad_perr", 32'(parity_err), 32'd1);
        handshake("7e1_bad");
        send_frame(9'h041, 4'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        check_hold("7e1_ok");
        handshake("7e1_ok");

        // 9O2, second stop bit low
        send_frame(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        check_hold("9o2");
        chk("9o2_ferr_abs", 32'(frame_err), 32'd1);
        handshake("9o2");

        // False start: four low ticks
        repeat (4) tick(1'b0);
        idle(30);
        chk("false_start_valid", 32'(dout_valid), 32'd0);
        chk("false_start_busy", 32'(busy), 32'd0);

        // One-tick high glitch inside a zero data bit
        send_frame(9'h055, 4'd8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        check_hold("glitch");
        handshake("glitch");

        // Overrun
        send_frame(9'h011, 4'd8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        send_frame(9'h022, 4'd8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        check_hold("overrun");
        chk("overrun_word", 32'(dout), 32'h011);
        handshake("overrun");

        // Break: line low for 20 bit times
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        repeat (20 * OVS) tick(1'b0);
        exp_brk++;
        exp_valid = 1'b1; exp_word = 9'd0; exp_pe = 1'b0; exp_fe = 1'b1;
        check_hold("break");
        handshake("break");
        idle(20);
        send_frame(9'h03C, 4'd8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        check_hold("after_break");
        handshake("after_break");

        // Randomized frames with mid-frame cfg changes
        for (int n = 0; n < 10; n++) begin
            rd   = 9'($urandom);
            rdb  = 4'($urandom_range(4, 10));
            rpar = 2'($urandom);
            rp   = 1'($urandom);
            rst2 = 1'($urandom);
            rs1  = rst2 ? 1'($urandom) : 1'b1;
            send_frame(rd, rdb, rpar, rp, rs1, 1'b1, rst2, -1, 1'b1);
            check_hold($sformatf("rand%0d", n));
            handshake($sformatf("rand%0d", n));
        end

        // Asynchronous reset in the middle of the data bits
        cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        play_bit(1'b0, -1);
        play_bit(1'b1, -1);
        play_bit(1'b0, -1);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        idle(40);
        chk("post_rst_valid", 32'(dout_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
